// File: rtl/counter_pkg.sv
// Shared types and constants for the loadable up-counter.
// Optional build macro: COUNTER_SATURATE_EN (saturate instead of wrap).
package counter_pkg;

    localparam int unsigned MAX_W = 64;

    localparam logic [MAX_W-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2
    } op_e;

    function automatic logic [MAX_W-1:0] ones_mask(input int unsigned w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Next-count datapath: load, increment with wrap or saturate, or hold.
// COUNTER_SATURATE_EN selects saturation at all-ones instead of wrap.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] nxt_o
);

    localparam logic [WIDTH-1:0] ONES = WIDTH'(ones_mask(WIDTH));

    logic [WIDTH-1:0] inc;

`ifdef COUNTER_SATURATE_EN
    assign inc = (cnt_i == ONES) ? ONES : cnt_i + 1'b1;
`else
    assign inc = cnt_i + 1'b1;
`endif

    always_comb begin
        nxt_o = cnt_i;
        unique case (op_i)
            OP_LOAD: nxt_o = data_i;
            OP_INC:  nxt_o = inc;
            default: nxt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/counter.sv
// Loadable up-counter with enable and terminal-count flag.
// Build macro COUNTER_SATURATE_EN makes the count saturate at all-ones.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             En,
    output logic [WIDTH-1:0] data_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONES = WIDTH'(ones_mask(WIDTH));
    localparam logic [WIDTH-1:0] ZW   = WIDTH'(ZERO);

    op_e              op;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Load takes precedence over count; reset is handled by the register.
    always_comb begin
        op = OP_HOLD;
        if (load)    op = OP_LOAD;
        else if (En) op = OP_INC;
    end

    counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .op_i   (op),
        .cnt_i  (cnt_q),
        .data_i (data_in),
        .nxt_o  (cnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= ZW;
        else     cnt_q <= cnt_d;
    end

    assign data_out = cnt_q;
    assign tc       = (cnt_q == ONES);

endmodule

// File: tb/tb_counter.sv
// Randomized self-checking bench for counter against a behavioural model.
// Honours COUNTER_SATURATE_EN in the reference model.
module tb_counter;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       load;
    logic       En;
    logic [7:0] data_out;
    logic       tc;

    int checks;
    int failures;
    int model;

    counter #(
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .load     (load),
        .En       (En),
        .data_out (data_out),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_next(input int cur, input bit r,
                                      input bit ld, input bit en,
                                      input int din);
        if (r)  return 0;
        if (ld) return din;
        if (en) begin
`ifdef COUNTER_SATURATE_EN
            return (cur == 255) ? 255 : cur + 1;
`else
            return (cur + 1) % 256;
`endif
        end
        return cur;
    endfunction

    task automatic check_out(input string tag);
        chk({tag, ".q"}, int'(data_out), model);
        chk({tag, ".tc"}, int'(tc), (model == 255) ? 1 : 0);
    endtask

    // Apply inputs at the falling edge, check 1ns after the rising edge.
    task automatic step(input string tag, input bit r, input bit ld,
                        input bit en, input int din);
        @(negedge clk);
        rst     = r;
        load    = ld;
        En      = en;
        data_in = 8'(din);
        @(posedge clk);
        #1;
        model = model_next(model, r, ld, en, din);
        check_out(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model    = 0;
        rst      = 1'b1;
        load     = 1'b0;
        En       = 1'b0;
        data_in  = '0;
        #1;
        check_out("reset_async");

        step("reset_hold", 1, 0, 0, 0);

        step("load55", 0, 1, 0, 'h55);
        step("load10", 0, 1, 0, 'h10);
        step("load70", 0, 1, 0, 'h70);

        step("rst_noload", 1, 0, 0, 'h60);
        step("rst_withload", 1, 1, 0, 'h60);

        step("count1", 0, 0, 1, 0);

        // En glitches low mid-cycle but is high again at the edge.
        @(negedge clk);
        #1 En = 1'b0;
        #2 En = 1'b1;
        @(posedge clk);
        #1;
        model = model_next(model, 0, 0, 1, 0);
        check_out("count2_glitch");

        step("hold", 0, 0, 0, 'hAA);

        // Asynchronous reset between edges.
        step("load23", 0, 1, 0, 'h23);
        @(negedge clk);
        load = 1'b0;
        En   = 1'b1;
        #1 rst = 1'b1;
        #1;
        model = 0;
        check_out("rst_midcycle");
        @(posedge clk);
        #1;
        check_out("rst_held_edge");
        step("rst_release", 0, 0, 1, 0);

        step("loadFF", 0, 1, 0, 'hFF);
        step("wrap_or_sat", 0, 0, 1, 0);
        step("load_beats_en", 0, 1, 1, 'h3C);

        for (int i = 0; i < 400; i++) begin
            bit r, ld, en;
            int din;
            r   = ($urandom_range(0, 24) == 0);
            ld  = ($urandom_range(0, 3) == 0);
            en  = ($urandom_range(0, 1) == 1);
            din = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) din = 'hFE + $urandom_range(0, 1);
            step("rand", r, ld, en, din);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
